icache_assoc: RTL and testbench

//  Parametrised set-associative instruction cache with multi-word lines, replacing the single-word direct-mapped icache.

---
 rtl/icache_assoc_if.sv | 22 ++
 rtl/icache_assoc.sv | 164 ++++++++++++++++
 tb/tb_icache_assoc.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_assoc_if.sv
// Fetch-side request/response and word-serial refill bus of the set-associative icache.
interface icache_assoc_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport master (
    output req_valid, req_addr, mem_valid, mem_data,
    input  req_ready, resp_valid, resp_data, mem_req, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, mem_valid, mem_data,
    output req_ready, resp_valid, resp_data, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache, round-robin replacement, word-serial line refill.
// Optional hit/miss counters when ICACHE_PERF_EN is defined.
module icache_assoc #(
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  icache_assoc_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);
  localparam int WO_W  = $clog2(LINE_WORDS);
  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = 30 - WO_W - SET_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_e;

  state_e             state_q, state_d;
  logic [31:2]        raddr_q;
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAY_W-1:0]   rr_q    [SETS];
  logic [WAY_W-1:0]   victim_q;
  logic [WO_W-1:0]    cnt_q;
  logic [31:0]        word_q;
  logic               flushed_q;
  logic               resp_valid_q;
  logic [31:0]        resp_data_q;

  logic [TAG_W-1:0]   tag_q  [SETS][WAYS];
  logic [31:0]        data_q [SETS][WAYS][LINE_WORDS];

  logic [WO_W-1:0]    r_word;
  logic [SET_W-1:0]   r_set;
  logic [TAG_W-1:0]   r_tag;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [31:0]        hit_word;
  logic               accept, beat, last;
  logic               unused_lsbs;

  assign r_word      = raddr_q[WO_W+1:2];
  assign r_set       = raddr_q[WO_W+SET_W+1:WO_W+2];
  assign r_tag       = raddr_q[31:WO_W+SET_W+2];
  assign unused_lsbs = ^bus.req_addr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[r_set][w] && tag_q[r_set][w] == r_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end
  assign hit_word = data_q[r_set][hit_way][r_word];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    beat    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        state_d = LOOKUP;
      end
      LOOKUP: state_d = hit ? IDLE : REFILL;
      REFILL: if (bus.mem_valid) begin
        beat = 1'b1;
        if (&cnt_q) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      raddr_q      <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      flushed_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (rdy_in) begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      if (accept) raddr_q <= bus.req_addr[31:2];
      if (state_q == LOOKUP) begin
        if (hit) begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= hit_word;
        end else begin
          victim_q  <= rr_q[r_set];
          cnt_q     <= '0;
          flushed_q <= 1'b0;
        end
      end
      // A flush seen anywhere in the refill keeps the incoming line invalid
      if (state_q == REFILL && flush_in) flushed_q <= 1'b1;
      if (beat) begin
        cnt_q <= cnt_q + WO_W'(1);
        if (cnt_q == r_word) word_q <= bus.mem_data;
      end
      if (last) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= (cnt_q == r_word) ? bus.mem_data : word_q;
        rr_q[r_set]  <= (WAYS == 1) ? '0 : rr_q[r_set] + WAY_W'(1);
      end
      if (flush_in) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (last && !flushed_q) begin
        valid_q[r_set][victim_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && beat) begin
      data_q[r_set][victim_q][cnt_q] <= bus.mem_data;
      if (last) tag_q[r_set][victim_q] <= r_tag;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mem_req    = (state_q == REFILL);
  assign bus.mem_addr   = (state_q == REFILL) ? {raddr_q[31:WO_W+2], cnt_q, 2'b00} : '0;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_in && state_q == LOOKUP) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: line-store reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_icache_assoc;
  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int LW   = 4;

  logic clk_in   = 1'b0;
  logic rst_in   = 1'b0;
  logic rdy_in   = 1'b1;
  logic flush_in = 1'b0;
  bit   mem_rand = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  icache_assoc_if bus();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_assoc #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  logic [31:0] mem_tab [logic [31:0]];

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem_tab.exists(a)) return mem_tab[a];
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] lbase(input logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction
  function automatic int setof(input logic [31:0] a);
    return int'(((a >> 2) / LW) % SETS);
  endfunction
  function automatic int wordof(input logic [31:0] a);
    return int'((a >> 2) % LW);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: answers whatever address the cache presents
  always @(negedge clk_in) begin
    bus.mem_valid = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    bus.mem_data  = memrd(bus.mem_addr);
  end

  // Reference model: a store of whole lines plus one outstanding request
  bit          m_v   [SETS][WAYS];
  logic [31:0] m_tag [SETS][WAYS];
  logic [31:0] m_d   [SETS][WAYS][LW];
  int          m_rr  [SETS];
  logic [31:0] m_buf [LW];
  bit          m_act, m_look, m_fl;
  logic [31:0] m_a, m_hits, m_miss;
  int          m_fill, m_vic, m_s, m_hw;
  logic        e_ready, e_mreq, e_rv;
  logic [31:0] e_maddr, e_rd;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < SETS; s++) begin
        m_rr[s] = 0;
        for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
      end
      m_act = 0; m_look = 0; m_fl = 0; m_fill = 0;
      m_hits = 0; m_miss = 0;
      e_ready = 1; e_mreq = 0; e_maddr = 0; e_rv = 0; e_rd = 0;
    end else if (rdy_in) begin
      e_rv = 0;
      if (!m_act) begin
        if (bus.req_valid) begin
          m_act = 1; m_look = 1; m_a = bus.req_addr;
        end
      end else if (m_look) begin
        m_s  = setof(m_a);
        m_hw = -1;
        for (int w = 0; w < WAYS; w++)
          if (m_hw < 0 && m_v[m_s][w] && m_tag[m_s][w] == lbase(m_a)) m_hw = w;
        if (m_hw >= 0) begin
          e_rv = 1; e_rd = m_d[m_s][m_hw][wordof(m_a)];
          m_act = 0; m_hits = m_hits + 1;
        end else begin
          m_miss = m_miss + 1;
          m_look = 0; m_fill = 0; m_vic = m_rr[m_s]; m_fl = 0;
        end
      end else begin
        if (flush_in) m_fl = 1;
        if (bus.mem_valid) begin
          m_buf[m_fill] = memrd(lbase(m_a) + 32'(4 * m_fill));
          m_fill++;
          if (m_fill == LW) begin
            m_s = setof(m_a);
            m_tag[m_s][m_vic] = lbase(m_a);
            for (int k = 0; k < LW; k++) m_d[m_s][m_vic][k] = m_buf[k];
            m_v[m_s][m_vic] = !m_fl;
            m_rr[m_s] = (m_rr[m_s] + 1) % WAYS;
            e_rv = 1; e_rd = m_buf[wordof(m_a)];
            m_act = 0; m_fill = 0;
          end
        end
      end
      if (flush_in)
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
      e_ready = !m_act;
      e_mreq  = m_act && !m_look;
      e_maddr = e_mreq ? lbase(m_a) + 32'(4 * m_fill) : 32'h0;
    end
  end

  always @(negedge clk_in) begin
    if (rst_in) begin
      chk("req_ready",  32'(bus.req_ready),  32'(e_ready));
      chk("mem_req",    32'(bus.mem_req),    32'(e_mreq));
      chk("mem_addr",   bus.mem_addr,        e_maddr);
      chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
      if (e_rv) chk("resp_data", bus.resp_data, e_rd);
`ifdef ICACHE_PERF_EN
      chk("hit_cnt",  hit_cnt,  m_hits);
      chk("miss_cnt", miss_cnt, m_miss);
`endif
    end
  end

  task automatic do_req(input logic [31:0] a, input int flush_at,
                        output logic [31:0] d, output logic missed, output int lat);
    int i;
    bit got;
    missed = 0; d = '0; lat = -1; got = 0;
    i = 0;
    while (!bus.req_ready && i < 50) begin @(negedge clk_in); i++; end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    @(negedge clk_in);
    bus.req_valid = 1'b0;
    for (i = 0; i < 50 && !got; i++) begin
      if (bus.mem_req) missed = 1;
      if (bus.resp_valid) begin
        got = 1; d = bus.resp_data; lat = i;
      end else begin
        flush_in = (i == flush_at);
        @(negedge clk_in);
      end
    end
    flush_in = 1'b0;
    chk("resp_arrived", 32'(got), 32'd1);
  endtask

  task automatic req_chk(input logic [31:0] a, input logic exp_miss,
                         input logic [31:0] exp_d, input int exp_lat);
    logic [31:0] d;
    logic        m;
    int          l;
    do_req(a, -1, d, m, l);
    chk($sformatf("miss_%03h", a), 32'(m), 32'(exp_miss));
    chk($sformatf("data_%03h", a), d, exp_d);
    if (exp_lat >= 0) chk($sformatf("lat_%03h", a), l, exp_lat);
  endtask

  initial begin
    logic [31:0] d;
    logic        m;
    int          l;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    for (int k = 0; k < 4; k++) mem_tab[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);

    repeat (3) @(negedge clk_in);
    chk("rst_ready",     32'(bus.req_ready),  32'd1);
    chk("rst_resp_v",    32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data,       32'd0);
    chk("rst_mem_req",   32'(bus.mem_req),    32'd0);
    chk("rst_mem_addr",  bus.mem_addr,        32'd0);
    rst_in = 1'b1;

    // basic miss then hit in the same line
    req_chk(32'h100, 1'b1, 32'hA0, 5);
    req_chk(32'h108, 1'b0, 32'hA2, 1);
`ifdef ICACHE_PERF_EN
    chk("perf_hit_1",  hit_cnt,  32'd1);
    chk("perf_miss_1", miss_cnt, 32'd1);
`endif

    // flush while idle, then flush during a refill
    @(negedge clk_in); flush_in = 1'b1;
    @(negedge clk_in); flush_in = 1'b0;
    req_chk(32'h100, 1'b1, 32'hA0, 5);
    do_req(32'h400, 2, d, m, l);
    chk("fl_refill_miss", 32'(m), 32'd1);
    chk("fl_refill_data", d, memrd(32'h400));
    req_chk(32'h400, 1'b1, memrd(32'h400), 5);

    // stall mid-refill
    bus.req_valid = 1'b1; bus.req_addr = 32'h504;
    @(negedge clk_in);
    bus.req_valid = 1'b0;
    l = 0;
    while (bus.mem_addr !== 32'h508 && l < 20) begin @(negedge clk_in); l++; end
    chk("stall_reach", bus.mem_addr, 32'h508);
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      chk("stall_addr", bus.mem_addr, 32'h508);
      chk("stall_req",  32'(bus.mem_req), 32'd1);
    end
    rdy_in = 1'b1;
    l = 0;
    while (!bus.resp_valid && l < 20) begin @(negedge clk_in); l++; end
    chk("stall_resp_v", 32'(bus.resp_valid), 32'd1);
    chk("stall_data",   bus.resp_data, memrd(32'h504));
    req_chk(32'h50C, 1'b0, memrd(32'h50C), 1);

    // asynchronous reset in the middle of a refill
    bus.req_valid = 1'b1; bus.req_addr = 32'h7F0;
    @(negedge clk_in);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("ar_in_refill", 32'(bus.mem_req), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("ar_mem_req",  32'(bus.mem_req),   32'd0);
    chk("ar_mem_addr", bus.mem_addr,       32'd0);
    chk("ar_ready",    32'(bus.req_ready), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
`ifdef ICACHE_PERF_EN
    chk("perf_hit_rst",  hit_cnt,  32'd0);
    chk("perf_miss_rst", miss_cnt, 32'd0);
`endif

    // round-robin victim selection in set 0
    req_chk(32'h100, 1'b1, 32'hA0, 5);
    req_chk(32'h200, 1'b1, memrd(32'h200), 5);
    req_chk(32'h300, 1'b1, memrd(32'h300), 5);
    req_chk(32'h200, 1'b0, memrd(32'h200), 1);
    req_chk(32'h300, 1'b0, memrd(32'h300), 1);
    req_chk(32'h100, 1'b1, 32'hA0, 5);
    req_chk(32'h30C, 1'b0, memrd(32'h30C), 1);
    req_chk(32'h200, 1'b1, memrd(32'h200), 5);
    req_chk(32'h7F0, 1'b1, memrd(32'h7F0), 5);

    // randomized traffic with stalls, flushes and gappy memory
    mem_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rdy_in        = ($urandom_range(0, 7) != 0);
      flush_in      = ($urandom_range(0, 49) == 0);
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_addr  = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 4)
                    | 32'($urandom_range(0, 15));
      @(negedge clk_in);
    end
    rdy_in = 1'b1; flush_in = 1'b0; bus.req_valid = 1'b0; mem_rand = 1'b0;
    l = 0;
    while (!bus.req_ready && l < 50) begin @(negedge clk_in); l++; end
    chk("drain_idle", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
